// File: rtl/csa_pkg.sv
// Shared helpers for the carry-save reduction tree: level/row bookkeeping,
// output width derivation and the valid/ready handshake bundle.
package csa_pkg;

    // One side of a valid/ready stream.
    typedef struct packed {
        logic valid;
        logic ready;
    } csa_hs_t;

    // Number of rows remaining after lvl levels of 3:2 compression.
    function automatic int csa_rows_at(input int n, input int lvl);
        int rows;
        rows = n;
        for (int i = 0; i < lvl; i++) begin
            rows = rows - rows / 3;
        end
        return rows;
    endfunction

    // Number of 3:2 levels needed to bring n rows down to two.
    function automatic int csa_levels(input int n);
        int rows;
        int lvls;
        rows = n;
        lvls = 0;
        for (int i = 0; i < 64; i++) begin
            if (rows > 2) begin
                rows = rows - rows / 3;
                lvls = lvls + 1;
            end
        end
        return lvls;
    endfunction

    // Width that holds the exact sum of rows operands of width bits.
    function automatic int csa_out_w(input int rows, input int width);
        return width + $clog2(rows);
    endfunction

endpackage

// File: rtl/csa_3_2_row.sv
// Bitwise 3:2 counter across one row triple. The carry row is returned
// already weighted (shifted left by one); the bit shifted past the top is
// dropped because the tree width already holds the full total.
module csa_3_2_row #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry
);

    logic [WIDTH-1:0] maj;

    assign sum   = a ^ b ^ c;
    assign maj   = (a & b) | (a & c) | (b & c);
    assign carry = maj << 1;

endmodule

// File: rtl/csa_tree_pipe.sv
// Pipelined carry-save reduction tree: NUM_ROWS operands are compressed by
// levels of 3:2 counters into a (sum, carry) pair, with a register stage after
// every LEVELS_PER_STAGE levels and an optional final carry-propagate stage.
// A single global stall holds every stage while the output is blocked.
module csa_tree_pipe
    import csa_pkg::*;
#(
    parameter int NUM_ROWS         = 8,
    parameter int WIDTH            = 16,
    parameter int LEVELS_PER_STAGE = 1,
    parameter int FINAL_ADD        = 0,
    parameter int OUT_W            = csa_out_w(NUM_ROWS, WIDTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_ROWS*WIDTH-1:0] in_rows,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_W-1:0]          out_sum,
    output logic [OUT_W-1:0]          out_carry
);

    localparam int L           = csa_levels(NUM_ROWS);
    localparam int TREE_STAGES = (L + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;
    localparam int STAGES      = TREE_STAGES + ((FINAL_ADD != 0) ? 1 : 0);

    csa_hs_t           out_hs;
    logic              advance;
    logic [STAGES-1:0] vld_p;

    assign out_hs    = '{valid: vld_p[STAGES-1], ready: out_ready};
    assign advance   = !out_hs.valid || out_hs.ready;
    assign in_ready  = advance;
    assign out_valid = vld_p[STAGES-1];

    // Valid bits travel one stage per advance; bubbles are kept, not collapsed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p <= '0;
        end else if (advance) begin
            vld_p[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                vld_p[k] <= vld_p[k-1];
            end
        end
    end

    for (genvar l = 0; l < L; l++) begin : g_lvl
        localparam int N_IN     = csa_rows_at(NUM_ROWS, l);
        localparam int GROUPS   = N_IN / 3;
        localparam int N_OUT    = N_IN - GROUPS;
        localparam bit BOUNDARY = ((l + 1) % LEVELS_PER_STAGE == 0) || (l == L - 1);

        logic [OUT_W-1:0] rows_in  [N_IN];
        logic [OUT_W-1:0] rows_out [N_OUT];
        logic [OUT_W-1:0] fwd      [N_OUT];

        if (l == 0) begin : g_src
            for (genvar r = 0; r < N_IN; r++) begin : g_row
                assign rows_in[r] = OUT_W'(in_rows[r*WIDTH +: WIDTH]);
            end
        end else begin : g_chain
            for (genvar r = 0; r < N_IN; r++) begin : g_row
                assign rows_in[r] = g_lvl[l-1].fwd[r];
            end
        end

        for (genvar gi = 0; gi < GROUPS; gi++) begin : g_grp
            csa_3_2_row #(
                .WIDTH (OUT_W)
            ) u_csa (
                .a     (rows_in[3*gi]),
                .b     (rows_in[3*gi+1]),
                .c     (rows_in[3*gi+2]),
                .sum   (rows_out[2*gi]),
                .carry (rows_out[2*gi+1])
            );
        end

        for (genvar k = 0; k < N_IN - 3*GROUPS; k++) begin : g_pass
            assign rows_out[2*GROUPS+k] = rows_in[3*GROUPS+k];
        end

        if (BOUNDARY) begin : g_reg
            // Stage register closing this group of levels.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int r = 0; r < N_OUT; r++) begin
                        fwd[r] <= '0;
                    end
                end else if (advance) begin
                    fwd <= rows_out;
                end
            end
        end else begin : g_comb
            assign fwd = rows_out;
        end
    end

    if (FINAL_ADD != 0) begin : g_final
        logic [OUT_W-1:0] total_p;

        // Extra stage resolving the redundant pair into one binary total.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                total_p <= '0;
            end else if (advance) begin
                total_p <= g_lvl[L-1].fwd[0] + g_lvl[L-1].fwd[1];
            end
        end

        assign out_sum   = total_p;
        assign out_carry = '0;
    end else begin : g_direct
        assign out_sum   = g_lvl[L-1].fwd[0];
        assign out_carry = g_lvl[L-1].fwd[1];
    end

endmodule

// File: tb/tb_csa_tree_pipe.sv
// Bench for csa_tree_pipe: scoreboard on the default 8x16 tree plus a small
// FINAL_ADD=1, three-row instance for the resolved-total path.
module tb_csa_tree_pipe;

    localparam int NR  = 8;
    localparam int W   = 16;
    localparam int OW  = 19;
    localparam int NRB = 3;
    localparam int OWB = 18;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [NR*W-1:0]   in_rows;
    logic              out_valid;
    logic              out_ready;
    logic [OW-1:0]     out_sum;
    logic [OW-1:0]     out_carry;

    logic              in_valid_b;
    logic              in_ready_b;
    logic [NRB*W-1:0]  in_rows_b;
    logic              out_valid_b;
    logic              out_ready_b;
    logic [OWB-1:0]    out_sum_b;
    logic [OWB-1:0]    out_carry_b;

    csa_tree_pipe #(
        .NUM_ROWS         (NR),
        .WIDTH            (W),
        .LEVELS_PER_STAGE (1),
        .FINAL_ADD        (0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rows   (in_rows),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry)
    );

    csa_tree_pipe #(
        .NUM_ROWS         (NRB),
        .WIDTH            (W),
        .LEVELS_PER_STAGE (1),
        .FINAL_ADD        (1)
    ) dut_fa (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_b),
        .in_ready  (in_ready_b),
        .in_rows   (in_rows_b),
        .out_valid (out_valid_b),
        .out_ready (out_ready_b),
        .out_sum   (out_sum_b),
        .out_carry (out_carry_b)
    );

    int errors = 0;
    int checks = 0;
    int n_out  = 0;
    logic [OW-1:0] exp_q [$];
    logic [OW-1:0] mon_exp;
    logic [OW-1:0] mon_tot;
    logic [OW-1:0] tot;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NR*W-1:0] rand_rows();
        logic [NR*W-1:0] v;
        for (int r = 0; r < NR; r++) begin
            v[r*W +: W] = W'($urandom);
        end
        return v;
    endfunction

    function automatic logic [OW-1:0] ref_sum(input logic [NR*W-1:0] rows);
        logic [OW-1:0] acc;
        acc = '0;
        for (int r = 0; r < NR; r++) begin
            acc = acc + {3'b000, rows[r*W +: W]};
        end
        return acc;
    endfunction

    // Scoreboard: push on accept, pop and compare on emit.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("sb_unexpected_out", 1, 0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    mon_tot = out_sum + out_carry;
                    check_val("sb_total", mon_tot, mon_exp);
                end
                n_out++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_sum(in_rows));
            end
        end
    end

    task automatic lat_check(input string tag, input logic [NR*W-1:0] rows, input logic [OW-1:0] exp_tot);
        in_rows  = rows;
        in_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) in_valid = 1'b0;
            check_val({tag, "_vld"}, out_valid, (k == 4) ? 1 : 0);
        end
        tot = out_sum + out_carry;
        check_val({tag, "_tot"}, tot, exp_tot);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        check_val(tag, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1);
    end

    initial begin
        int n0;
        int sent;
        logic [OW-1:0] s0;
        logic [OW-1:0] c0;
        logic [NR*W-1:0] ones;

        rst_n       = 1'b0;
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        in_rows     = rand_rows();
        in_valid_b  = 1'b1;
        out_ready_b = 1'b1;
        in_rows_b   = '1;

        // Reset held for three cycles with input offered.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check_val("rst_out_valid", out_valid, 0);
            check_val("rst_out_sum", out_sum, 0);
            check_val("rst_out_carry", out_carry, 0);
            check_val("rst_in_ready", in_ready, 1);
            check_val("rst_b_out_valid", out_valid_b, 0);
        end
        in_valid   = 1'b0;
        in_valid_b = 1'b0;
        rst_n      = 1'b1;
        @(posedge clk);
        #1;

        // All rows at maximum.
        ones = '1;
        lat_check("max", ones, 19'h7FFF8);
        repeat (2) @(posedge clk);
        #1;

        // FINAL_ADD instance: rows 1, 2, 3.
        in_rows_b  = {16'd3, 16'd2, 16'd1};
        in_valid_b = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) in_valid_b = 1'b0;
            check_val("fa_vld", out_valid_b, (k == 2) ? 1 : 0);
        end
        check_val("fa_sum", out_sum_b, 6);
        check_val("fa_carry", out_carry_b, 0);

        // 100 back-to-back random sets.
        n0 = n_out;
        for (int i = 0; i < 100; i++) begin
            in_rows  = rand_rows();
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_val("stream_count", n_out - n0, 100);
        drain("stream_drain");

        // Backpressure with the pipe full.
        n0 = n_out;
        sent = 0;
        for (int i = 0; i < 6; i++) begin
            in_rows  = rand_rows();
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            sent++;
        end
        in_rows   = rand_rows();
        out_ready = 1'b0;
        s0 = out_sum;
        c0 = out_carry;
        check_val("stall_out_valid", out_valid, 1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check_val("stall_in_ready", in_ready, 0);
            check_val("stall_sum_hold", out_sum, s0);
            check_val("stall_carry_hold", out_carry, c0);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            sent++;
            in_rows = rand_rows();
        end
        in_valid = 1'b0;
        drain("stall_drain");
        check_val("stall_count", n_out - n0, sent);

        // Random bubbles and random backpressure.
        for (int i = 0; i < 40; i++) begin
            in_rows   = rand_rows();
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain("random_drain");

        // Reset with three sets in flight.
        for (int i = 0; i < 3; i++) begin
            in_rows  = rand_rows();
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check_val("midrst_no_emit", out_valid, 0);
        end
        in_rows = rand_rows();
        lat_check("midrst_next", in_rows, ref_sum(in_rows));
        drain("final_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
